// File: rtl/stepper_move_sequencer.sv
// Move scheduler in front of the stepper PWM driver: queues (dir, cycles) commands and times each move.
// Define STEPPER_SEQ_POS_EN to add the signed pos phase counter and its pos_clr input.
module stepper_move_sequencer #(
    parameter int DEPTH      = 4,
    parameter int PHASE_CLKS = 2313,
    parameter int GAP_CLKS   = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [9:0]              cmd_cycles,
    input  logic                    abort,
`ifdef STEPPER_SEQ_POS_EN
    input  logic                    pos_clr,
    output logic signed [15:0]      pos,
`endif
    output logic                    motor_en,
    output logic                    motor_dir,
    output logic [9:0]              motor_cycles,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [$clog2(DEPTH):0]  q_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

    state_t        state, state_next;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] clk_cnt;
    logic [10:0]   phase_cnt;
    logic [GW-1:0] gap_cnt;
    logic          push, pop, flush, start_gap, done_set, aborted_set;
    logic          q_empty, phase_wrap, run_last, gap_last;

    assign q_empty    = (q_level == '0);
    assign cmd_ready  = (q_level < LW'(DEPTH)) && !abort;
    assign push       = cmd_valid && cmd_ready;
    assign phase_wrap = (state == RUN) && (clk_cnt == CW'(PHASE_CLKS - 1));
    // 11-bit compare so a 1023-cycle command still terminates after 1024 phases
    assign run_last   = phase_wrap && ((phase_cnt + 11'd1) == ({1'b0, motor_cycles} + 11'd1));
    assign gap_last   = (state == GAP) && (gap_cnt == GW'(GAP_CLKS - 1));
    assign motor_en   = (state != RUN);
    assign busy       = (state != IDLE) || !q_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        flush       = 1'b0;
        start_gap   = 1'b0;
        done_set    = 1'b0;
        aborted_set = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    flush       = 1'b1;
                    aborted_set = !q_empty;
                end else if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                // abort outranks a RUN completion on the same edge
                if (abort) begin
                    flush       = 1'b1;
                    aborted_set = 1'b1;
                    start_gap   = 1'b1;
                    state_next  = GAP;
                end else if (state == LOAD) begin
                    state_next = RUN;
                end else if (state == RUN) begin
                    if (run_last) begin
                        done_set   = 1'b1;
                        start_gap  = 1'b1;
                        state_next = GAP;
                    end
                end else if (gap_last) begin
                    if (!q_empty) begin
                        pop        = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_dir, cmd_cycles};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_level      <= '0;
            motor_dir    <= 1'b0;
            motor_cycles <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            clk_cnt      <= '0;
            phase_cnt    <= '0;
            gap_cnt      <= '0;
        end else begin
            done    <= done_set;
            aborted <= aborted_set;
            if (flush) begin
                rd_ptr  <= wr_ptr;
                q_level <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) q_level <= q_level + LW'(1);
                else if (pop && !push) q_level <= q_level - LW'(1);
            end
            if (pop) begin
                {motor_dir, motor_cycles} <= mem[rd_ptr];
            end
            if (state == RUN && !phase_wrap) clk_cnt <= clk_cnt + CW'(1);
            else clk_cnt <= '0;
            if (state != RUN) phase_cnt <= '0;
            else if (phase_wrap) phase_cnt <= phase_cnt + 11'd1;
            if (start_gap || state != GAP) gap_cnt <= '0;
            else gap_cnt <= gap_cnt + GW'(1);
        end
    end

`ifdef STEPPER_SEQ_POS_EN
    // a phase cut short by abort on its final edge is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
        end else if (pos_clr) begin
            pos <= '0;
        end else if (phase_wrap && !abort) begin
            pos <= motor_dir ? pos + 16'sd1 : pos - 16'sd1;
        end
    end
`endif
endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Self-checking bench for stepper_move_sequencer: a single-move vector table, hand-written abort/reset
// sequences, and randomized command traffic scored against a queue of expected moves.
module tb_stepper_move_sequencer;
    localparam int DEPTH      = 4;
    localparam int PHASE_CLKS = 10;
    localparam int GAP_CLKS   = 4;
    localparam int RUN_LIMIT  = 12000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_dir, abort;
    logic [9:0]  cmd_cycles;
    logic        motor_en, motor_dir, busy, done, aborted;
    logic [9:0]  motor_cycles;
    logic [2:0]  q_level;
`ifdef STEPPER_SEQ_POS_EN
    logic               pos_clr;
    logic signed [15:0] pos;
`endif

    typedef struct packed { logic dir; logic [9:0] cycles; int run_clks; } vec_t;
    typedef struct packed { logic dir; logic [9:0] cycles; } cmd_t;

    vec_t vecs [4];
    cmd_t model_q [$];

    int checks = 0;
    int passes = 0;
    bit mon_on, gap_strict, in_run, seen_run, acc;
    int run_len, high_len, done_total, n, dones, aborts, held_bad, lows, pushed;
    logic       run_dir;
    logic [9:0] run_cyc;
    cmd_t       rnd_cmd;

    stepper_move_sequencer #(.DEPTH(DEPTH), .PHASE_CLKS(PHASE_CLKS), .GAP_CLKS(GAP_CLKS)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_cycles(cmd_cycles), .abort(abort),
`ifdef STEPPER_SEQ_POS_EN
        .pos_clr(pos_clr), .pos(pos),
`endif
        .motor_en(motor_en), .motor_dir(motor_dir), .motor_cycles(motor_cycles), .busy(busy),
        .done(done), .aborted(aborted), .q_level(q_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    endtask

    // Scoreboard: every motor_en-low stretch must match the oldest accepted command
    task automatic observe();
        cmd_t exp_cmd;
        if (done) done_total++;
        if (!abort) check_output("ready_vs_level", 32'(cmd_ready), 32'(q_level < DEPTH));
        if (!motor_en) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 0;
                if (seen_run) begin
                    if (gap_strict) check_output("gap_len", high_len, GAP_CLKS + 1);
                    else check_output("gap_min", 32'(high_len >= GAP_CLKS + 1), 1);
                end
                run_dir = motor_dir;
                run_cyc = motor_cycles;
            end
            run_len++;
        end else begin
            if (in_run) begin
                in_run   = 1'b0;
                seen_run = 1'b1;
                high_len = 0;
                check_output("run_expected", 32'(model_q.size() != 0), 1);
                if (model_q.size() != 0) begin
                    exp_cmd = model_q.pop_front();
                    check_output("run_len", run_len, (int'(exp_cmd.cycles) + 1) * PHASE_CLKS);
                    check_output("run_dir", 32'(run_dir), 32'(exp_cmd.dir));
                    check_output("run_cycles", 32'(run_cyc), 32'(exp_cmd.cycles));
                end
                check_output("done_at_gap", 32'(done), 1);
            end
            high_len++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_on) observe();
    endtask

    task automatic apply_stimulus(input logic dir, input logic [9:0] cyc, output bit ok);
        cmd_t c;
        cmd_dir    = dir;
        cmd_cycles = cyc;
        cmd_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                c.dir = dir;
                c.cycles = cyc;
                if (mon_on) model_q.push_back(c);
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check_output("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check_output("idle_reached", 32'(busy), 0);
    endtask

    task automatic reset_monitor();
        in_run = 0; seen_run = 0; run_len = 0; high_len = 0; done_total = 0;
        model_q.delete();
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_cycles = '0; abort = 1'b0;
        mon_on = 1'b0; gap_strict = 1'b0;
`ifdef STEPPER_SEQ_POS_EN
        pos_clr = 1'b0;
`endif
        vecs[0] = '{1'b1, 10'd2, 30};
        vecs[1] = '{1'b0, 10'd0, 10};
        vecs[2] = '{1'b1, 10'd7, 80};
        vecs[3] = '{1'b0, 10'd1023, 10240};

        #12;
        check_output("rst_motor_en", 32'(motor_en), 1);
        check_output("rst_motor_dir", 32'(motor_dir), 0);
        check_output("rst_motor_cycles", 32'(motor_cycles), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_aborted", 32'(aborted), 0);
        check_output("rst_cmd_ready", 32'(cmd_ready), 1);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_q_level", 32'(q_level), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        tick();

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].dir, vecs[v].cycles, acc);
            check_output("lvl_after_push", 32'(q_level), 1);
            check_output("busy_after_push", 32'(busy), 1);
            check_output("en_before_load", 32'(motor_en), 1);
            tick();
            check_output("en_in_load", 32'(motor_en), 1);
            check_output("dir_in_load", 32'(motor_dir), 32'(vecs[v].dir));
            check_output("cycles_in_load", 32'(motor_cycles), 32'(vecs[v].cycles));
            check_output("lvl_in_load", 32'(q_level), 0);
            tick();
            n = 0; dones = 0; held_bad = 0;
            while (!motor_en && n < RUN_LIMIT) begin
                n++;
                if (done) dones++;
                if (motor_dir !== vecs[v].dir || motor_cycles !== vecs[v].cycles) held_bad++;
                tick();
            end
            check_output("run_clks", n, vecs[v].run_clks);
            check_output("hold_in_run", held_bad, 0);
            check_output("done_first_gap", 32'(done), 1);
            if (done) dones++;
            for (int g = 1; g < GAP_CLKS; g++) begin
                tick();
                if (done) dones++;
                if (!motor_en) held_bad++;
            end
            check_output("en_during_gap", held_bad, 0);
            check_output("busy_last_gap", 32'(busy), 1);
            tick();
            check_output("busy_idle", 32'(busy), 0);
            check_output("done_count", dones, 1);
            check_output("dir_held_after", 32'(motor_dir), 32'(vecs[v].dir));
            check_output("cycles_held_after", 32'(motor_cycles), 32'(vecs[v].cycles));
            tick();
        end

        // Five commands back-to-back: the fifth fills the FIFO, runs separated by GAP+LOAD
        reset_monitor();
        mon_on = 1'b1; gap_strict = 1'b1;
        apply_stimulus(1'b1, 10'd0, acc);
        apply_stimulus(1'b0, 10'd1, acc);
        apply_stimulus(1'b1, 10'd2, acc);
        apply_stimulus(1'b0, 10'd0, acc);
        apply_stimulus(1'b1, 10'd3, acc);
        check_output("b2b_full_level", 32'(q_level), 4);
        check_output("b2b_ready_low", 32'(cmd_ready), 0);
        wait_idle(2000);
        check_output("b2b_done_total", done_total, 5);
        check_output("b2b_model_empty", model_q.size(), 0);
        mon_on = 1'b0;
        tick();

        // Abort in RUN phase 1 with two commands queued; a coinciding push is dropped
        apply_stimulus(1'b1, 10'd3, acc);
        apply_stimulus(1'b0, 10'd2, acc);
        apply_stimulus(1'b1, 10'd2, acc);
        check_output("abort_q_before", 32'(q_level), 2);
        for (int i = 0; i < 12; i++) tick();
        check_output("abort_in_run", 32'(motor_en), 0);
        abort = 1'b1; cmd_valid = 1'b1;
        #1;
        check_output("ready_during_abort", 32'(cmd_ready), 0);
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        check_output("abort_q_flushed", 32'(q_level), 0);
        check_output("abort_pulse", 32'(aborted), 1);
        check_output("abort_no_done", 32'(done), 0);
        check_output("abort_en_high", 32'(motor_en), 1);
        dones = 0; aborts = 0;
        for (int g = 1; g < GAP_CLKS; g++) begin
            tick();
            if (done) dones++;
            if (aborted) aborts++;
        end
        check_output("abort_busy_gap", 32'(busy), 1);
        tick();
        check_output("abort_idle", 32'(busy), 0);
        check_output("abort_gap_dones", dones, 0);
        check_output("abort_single_pulse", aborts, 0);
        tick();

        // Abort on the final RUN edge wins over completion
        apply_stimulus(1'b0, 10'd0, acc);
        tick();
        tick();
        for (int i = 0; i < PHASE_CLKS - 1; i++) tick();
        check_output("final_edge_en", 32'(motor_en), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("final_edge_aborted", 32'(aborted), 1);
        check_output("final_edge_done", 32'(done), 0);
        dones = 0;
        for (int g = 0; g < GAP_CLKS; g++) begin
            tick();
            if (done) dones++;
        end
        check_output("final_edge_late_done", dones, 0);
        check_output("final_edge_idle", 32'(busy), 0);

        // Abort in IDLE: pulse only when something was queued
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("idle_abort_empty", 32'(aborted), 0);
        apply_stimulus(1'b1, 10'd5, acc);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("idle_abort_queued", 32'(aborted), 1);
        check_output("idle_abort_level", 32'(q_level), 0);
        check_output("idle_abort_busy", 32'(busy), 0);
        tick();

        // Asynchronous reset in the middle of a move
        apply_stimulus(1'b1, 10'd2, acc);
        apply_stimulus(1'b0, 10'd1, acc);
        for (int i = 0; i < 5; i++) tick();
        check_output("pre_reset_run", 32'(motor_en), 0);
        rst = 1'b0;
        #1;
        check_output("async_rst_en", 32'(motor_en), 1);
        check_output("async_rst_level", 32'(q_level), 0);
        check_output("async_rst_busy", 32'(busy), 0);
        check_output("async_rst_cycles", 32'(motor_cycles), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        dones = 0; aborts = 0; lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
            if (aborted) aborts++;
            if (!motor_en) lows++;
        end
        check_output("post_rst_done", dones, 0);
        check_output("post_rst_aborted", aborts, 0);
        check_output("post_rst_no_run", lows, 0);

`ifdef STEPPER_SEQ_POS_EN
        check_output("pos_after_rst", int'(pos), 0);
        apply_stimulus(1'b0, 10'd3, acc);
        wait_idle(200);
        check_output("pos_reverse_4", int'(pos), -4);
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        check_output("pos_cleared", int'(pos), 0);
`endif

        // Randomized traffic against the expected-move queue
        reset_monitor();
        mon_on = 1'b1; gap_strict = 1'b0;
        pushed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pushed < 20 && $urandom_range(0, 2) == 0) begin
                cmd_dir    = 1'($urandom_range(0, 1));
                cmd_cycles = 10'($urandom_range(0, 3));
                cmd_valid  = 1'b1;
                #1;
                if (cmd_ready) begin
                    rnd_cmd.dir    = cmd_dir;
                    rnd_cmd.cycles = cmd_cycles;
                    model_q.push_back(rnd_cmd);
                    pushed++;
                end
            end
            tick();
            cmd_valid = 1'b0;
        end
        check_output("rnd_done_total", done_total, pushed);
        check_output("rnd_model_empty", model_q.size(), 0);
        check_output("rnd_idle", 32'(busy), 0);
        mon_on = 1'b0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
